// File: rtl/ftdi_tx_stream_arbiter.sv
// Round-robin arbiter sharing the FTDI write-side AXIS byte stream between NUM_SRC producers.
// Optional per-burst header byte (source id + continuation flag) enabled by FTDI_TX_ARB_HEADER_EN.
module ftdi_tx_stream_arbiter #(
    parameter int NUM_SRC   = 2,
    parameter int MAX_BURST = 256,
    parameter int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic                 ftdi_clko,
    input  logic                 res,
    input  logic                 enable,
    input  logic [NUM_SRC-1:0]   src_mask,
    input  logic [NUM_SRC*8-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]   s_axis_tvalid,
    input  logic [NUM_SRC-1:0]   s_axis_tlast,
    output logic [NUM_SRC-1:0]   s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [SRC_W-1:0]     grant_id,
    output logic                 busy
);

`ifdef FTDI_TX_ARB_HEADER_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_HDR = 2'd2} state_t;
    logic [NUM_SRC-1:0] cont_q, cont_d;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1} state_t;
`endif

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [NUM_SRC-1:0] req;
    logic               win_vld;
    logic [SRC_W-1:0]   win_idx;
    logic [SRC_W-1:0]   cand;
    logic               at_limit;
    logic               g_last;

    // Cyclic first-set search starting just after the last winner.
    always_comb begin
        req     = s_axis_tvalid & src_mask;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_W'((int'(ptr_q) + k) % NUM_SRC);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign at_limit = (cnt_q == 16'(MAX_BURST - 1));
    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        g_last        = 1'b0;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
`ifdef FTDI_TX_ARB_HEADER_EN
        cont_d        = cont_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable && win_vld) begin
                    grant_d = win_idx;
                    ptr_d   = win_idx;
                    cnt_d   = '0;
`ifdef FTDI_TX_ARB_HEADER_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_GRANT;
`endif
                end
            end
`ifdef FTDI_TX_ARB_HEADER_EN
            ST_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = {cont_q[grant_q], 3'b000, 4'(grant_q)};
                if (m_axis_tready) begin
                    state_d = ST_GRANT;
                end
            end
`endif
            ST_GRANT: begin
                g_last                 = s_axis_tlast[grant_q] | at_limit;
                m_axis_tdata           = s_axis_tdata[int'(grant_q)*8 +: 8];
                m_axis_tvalid          = s_axis_tvalid[grant_q];
                m_axis_tlast           = g_last;
                s_axis_tready[grant_q] = m_axis_tready;
                if (s_axis_tvalid[grant_q] && m_axis_tready) begin
                    cnt_d = cnt_q + 16'd1;
                    if (g_last) begin
                        state_d = ST_IDLE;
`ifdef FTDI_TX_ARB_HEADER_EN
                        cont_d[grant_q] = ~s_axis_tlast[grant_q];
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Block every handshake on the reset cycle so an aborted burst loses no byte.
        if (res) begin
            s_axis_tready = '0;
            m_axis_tdata  = '0;
            m_axis_tvalid = 1'b0;
            m_axis_tlast  = 1'b0;
        end
    end

    always_ff @(posedge ftdi_clko) begin
        if (res) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= SRC_W'(NUM_SRC - 1);
            cnt_q   <= '0;
`ifdef FTDI_TX_ARB_HEADER_EN
            cont_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
`ifdef FTDI_TX_ARB_HEADER_EN
            cont_q  <= cont_d;
`endif
        end
    end

endmodule
